// File: rtl/cnt_capture_fifo.sv
// Snapshots cnt into a first-word-fall-through FIFO on each rising edge of trig; flags captures lost to a full FIFO.
// Optional CAP_DROP_CNT_EN adds a saturating 8-bit drop_cnt output next to the sticky ovf flag.
module cnt_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt,
    input  logic             trig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW:0]      level,
    output logic             ovf,
    input  logic             ovf_clr
`ifdef CAP_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LEVEL  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             trig_q;
    logic             rise;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;

    assign rise = trig & ~trig_q;
    assign full = (level == FULL_LEVEL);
    assign pop  = out_valid & out_ready;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the capture.
    assign push = rise & (~full | pop);
    assign drop = rise & full & ~pop;

    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q <= 1'b1;
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            trig_q <= trig;
            if (push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            if (push && !pop) begin
                level <= level + ONE_LEVEL;
            end else if (pop && !push) begin
                level <= level - ONE_LEVEL;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // Storage needs no reset; entries are only visible through level/out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cnt;
        end
    end

`ifdef CAP_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (ovf_clr) begin
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cnt_capture_fifo.sv
// Bench for cnt_capture_fifo: queue model checked every cycle plus hand-computed directed expectations.
module tb_cnt_capture_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] cnt;
    logic             trig;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW:0]      level;
    logic             ovf;
    logic             ovf_clr;
`ifdef CAP_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    cnt_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .trig      (trig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`ifdef CAP_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: captured values held in a plain queue.
    logic [WIDTH-1:0] m_q[$];
    bit               m_trig_prev;
    bit               m_ovf;
    int               m_drops;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_trig_prev = 1'b1;
            m_ovf       = 1'b0;
            m_drops     = 0;
        end else begin
            bit rise_m;
            bit lost;
            rise_m = trig && !m_trig_prev;
            lost   = 1'b0;
            if (m_q.size() > 0 && out_ready) begin
                void'(m_q.pop_front());
            end
            if (rise_m) begin
                if (m_q.size() < DEPTH) m_q.push_back(cnt);
                else lost = 1'b1;
            end
            if (lost) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (ovf_clr) m_drops = lost ? 1 : 0;
            else if (lost && m_drops < 255) m_drops = m_drops + 1;
            m_trig_prev = trig;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_valid", int'(out_valid), int'(m_q.size() > 0));
        check("model_level", int'(level), m_q.size());
        check("model_ovf", int'(ovf), int'(m_ovf));
        if (m_q.size() > 0) check("model_data", int'(out_data), int'(m_q[0]));
`ifdef CAP_DROP_CNT_EN
        check("model_drop_cnt", int'(drop_cnt), m_drops);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_val(input logic [WIDTH-1:0] v);
        cnt  = v;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
    endtask

    task automatic check_drops(input string name, input int exp);
`ifdef CAP_DROP_CNT_EN
        check(name, int'(drop_cnt), exp);
`endif
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: run still active at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; trig = 1'b1; cnt = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        check("rst_valid", int'(out_valid), 0);
        check("rst_level", int'(level), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_data", int'(out_data), 0);
        check_drops("rst_drop_cnt", 0);

        // trig held high through reset release must not capture
        rst = 1'b0;
        tick(); tick(); tick();
        check("trig_thru_rst_level", int'(level), 0);
        trig = 1'b0;
        tick();

        // single capture, one cycle latency
        cnt = 8'h05; trig = 1'b1;
        tick();
        trig = 1'b0;
        check("single_valid", int'(out_valid), 1);
        check("single_data", int'(out_data), 8'h05);
        check("single_level", int'(level), 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("single_drained", int'(level), 0);

        // trig held for six cycles gives exactly one capture
        cnt = 8'h20; trig = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            cnt = cnt + 8'd1;
        end
        trig = 1'b0;
        check("held_level", int'(level), 1);
        check("held_data", int'(out_data), 8'h20);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // fill then overflow, drain in order
        for (int i = 0; i < 4; i++) push_val(8'(8'h10 + i));
        check("fill_level", int'(level), 4);
        push_val(8'h99);
        check("ovf_level", int'(level), 4);
        check("ovf_set", int'(ovf), 1);
        check_drops("ovf_drop_cnt", 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_order", int'(out_data), 8'h10 + i);
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", int'(level), 0);
        check("ovf_sticky", int'(ovf), 1);

        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_clr", int'(ovf), 0);
        check_drops("clr_drop_cnt", 0);

        // full FIFO, rise coinciding with pop is accepted
        for (int i = 0; i < 4; i++) push_val(8'(8'h30 + i));
        cnt = 8'h50; trig = 1'b1; out_ready = 1'b1;
        tick();
        trig = 1'b0; out_ready = 1'b0;
        check("full_pop_level", int'(level), 4);
        check("full_pop_ovf", int'(ovf), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("full_pop_last", int'(out_data), 8'h50);
        tick();
        check("full_pop_empty", int'(level), 0);

        // ten push/pop cycles walk the pointers around twice
        for (int i = 0; i < 10; i++) begin
            cnt = 8'(8'h60 + i); trig = 1'b1;
            tick();
            trig = 1'b0;
            check("wrap_data", int'(out_data), 8'h60 + i);
            tick();
        end
        out_ready = 1'b0;
        check("wrap_empty", int'(level), 0);

        // drop coinciding with ovf_clr: set wins
        for (int i = 0; i < 4; i++) push_val(8'(8'h70 + i));
        cnt = 8'h80; trig = 1'b1; ovf_clr = 1'b1;
        tick();
        trig = 1'b0; ovf_clr = 1'b0;
        check("drop_clr_ovf", int'(ovf), 1);
        check_drops("drop_clr_drop_cnt", 1);
        tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("clr_again", int'(ovf), 0);
        push_val(8'h81);
        check("ovf_before_rst", int'(ovf), 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("pre_rst_level", int'(level), 3);

        // asynchronous reset mid-cycle clears outputs before the next edge
        #1 rst = 1'b1;
        #1;
        check("async_valid", int'(out_valid), 0);
        check("async_level", int'(level), 0);
        check("async_ovf", int'(ovf), 0);
        check("async_data", int'(out_data), 0);
        tick();
        rst = 1'b0;
        tick(); tick();
        check("post_rst_level", int'(level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
